// File: rtl/matrix_loader_pkg.sv
// Shared types and constants for the matrix operand loader.
package matrix_loader_pkg;

  localparam int FRAME_LEN = 18;
  localparam int MAT_N     = 3;
  localparam int DATA_W    = 8;
  localparam int IDX_W     = 5;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    SKIP    = 2'd1,
    RUN     = 2'd2,
    RELEASE = 2'd3
  } state_e;

  // Width of a counter that must reach timeout-1.
  function automatic int timer_w(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/matrix_operand_loader_cycle_timer.sv
// Clear/enable counter that flags when it has reached LIMIT-1.
module cycle_timer #(
  parameter int LIMIT = 1024,
  parameter int W     = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == W'(LIMIT - 1));

  // Saturates at LIMIT-1; the owner leaves RUN on that cycle anyway.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                 cnt_d = '0;
    else if (en && !expired) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/matrix_operand_loader.sv
// Assembles an 18-byte stream frame into MAC operands, starts the MAC and
// supervises it; flags malformed frames and MAC stalls.
module matrix_operand_loader #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              clr_err,
  output logic [DATA_W-1:0] a11, a12, a13, a21, a22, a23, a31, a32, a33,
  output logic [DATA_W-1:0] b11, b12, b13, b21, b22, b23, b31, b32, b33,
  output logic              start,
  input  logic              done,
  output logic              busy,
  output logic              err_len,
  output logic              err_timeout
);
  import matrix_loader_pkg::*;

  localparam int               TW       = timer_w(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_e                           state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [FRAME_LEN-1:0][DATA_W-1:0] opnd_q, opnd_d;
  logic s_ready_q, s_ready_d, start_q, start_d, busy_q, busy_d;
  logic err_len_q, err_len_d, err_to_q, err_to_d;
  logic set_len, set_to, xfer, tmr_exp;

  assign xfer = s_valid && s_ready_q;

  cycle_timer #(.LIMIT(TIMEOUT), .W(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q != RUN),
    .en      (state_q == RUN),
    .expired (tmr_exp)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    opnd_d  = opnd_q;
    set_len = 1'b0;
    set_to  = 1'b0;
    case (state_q)
      LOAD: if (xfer) begin
        opnd_d[idx_q] = s_data;
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          if (s_last) state_d = RUN;
          else begin
            set_len = 1'b1;
            state_d = SKIP;
          end
        end else if (s_last) begin
          set_len = 1'b1;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SKIP: if (xfer && s_last) begin
        idx_d   = '0;
        state_d = LOAD;
      end
      RUN: begin
        // done wins over a timeout expiring on the same cycle
        if (done) state_d = RELEASE;
        else if (tmr_exp) begin
          set_to  = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: if (!done) begin
        idx_d   = '0;
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase

    s_ready_d = (state_d == LOAD) || (state_d == SKIP);
    start_d   = (state_d == RUN);
    busy_d    = (state_d == RUN) || (state_d == RELEASE);
    err_len_d = set_len || (err_len_q && !clr_err);
    err_to_d  = set_to  || (err_to_q  && !clr_err);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= LOAD;
      idx_q     <= '0;
      opnd_q    <= '0;
      s_ready_q <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_len_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      opnd_q    <= opnd_d;
      s_ready_q <= s_ready_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      err_len_q <= err_len_d;
      err_to_q  <= err_to_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign start       = start_q;
  assign busy        = busy_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_to_q;

  // Row-major: A in bytes 0..8, B in bytes 9..17.
  assign a11 = opnd_q[0];  assign a12 = opnd_q[1];  assign a13 = opnd_q[2];
  assign a21 = opnd_q[3];  assign a22 = opnd_q[4];  assign a23 = opnd_q[5];
  assign a31 = opnd_q[6];  assign a32 = opnd_q[7];  assign a33 = opnd_q[8];
  assign b11 = opnd_q[9];  assign b12 = opnd_q[10]; assign b13 = opnd_q[11];
  assign b21 = opnd_q[12]; assign b22 = opnd_q[13]; assign b23 = opnd_q[14];
  assign b31 = opnd_q[15]; assign b32 = opnd_q[16]; assign b33 = opnd_q[17];

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Self-checking bench: frame-level reference model, scenario table, hand
// sequences for timeout/reset/same-edge clear, and randomized frames.
module tb_matrix_operand_loader;
  localparam int DW = 8;
  localparam int TO = 1024;

  logic clk = 1'b0, rst = 1'b0;
  logic s_valid = 1'b0, s_last = 1'b0, clr_err = 1'b0, done = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic s_ready, start, busy, err_len, err_timeout;
  logic [DW-1:0] a11, a12, a13, a21, a22, a23, a31, a32, a33;
  logic [DW-1:0] b11, b12, b13, b21, b22, b23, b31, b32, b33;
  logic [DW-1:0] ops [18];

  int errors = 0, checks = 0, cyc = 0;
  logic [DW-1:0] exp_ops [18];
  bit exp_el = 1'b0, exp_et = 1'b0;

  typedef struct {
    int len; int gap; bit nom; bit clr_before; bit exp_start; bit exp_err_len;
  } vec_t;
  vec_t vecs [5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matrix_operand_loader #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .clr_err(clr_err),
    .a11(a11), .a12(a12), .a13(a13), .a21(a21), .a22(a22), .a23(a23),
    .a31(a31), .a32(a32), .a33(a33),
    .b11(b11), .b12(b12), .b13(b13), .b21(b21), .b22(b22), .b23(b23),
    .b31(b31), .b32(b32), .b33(b33),
    .start(start), .done(done), .busy(busy),
    .err_len(err_len), .err_timeout(err_timeout)
  );

  always_comb begin
    ops[0] = a11;  ops[1] = a12;  ops[2] = a13;
    ops[3] = a21;  ops[4] = a22;  ops[5] = a23;
    ops[6] = a31;  ops[7] = a32;  ops[8] = a33;
    ops[9] = b11;  ops[10] = b12; ops[11] = b13;
    ops[12] = b21; ops[13] = b22; ops[14] = b23;
    ops[15] = b31; ops[16] = b32; ops[17] = b33;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit ops_differ();
    for (int i = 0; i < 18; i++) if (ops[i] !== exp_ops[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_ops(input string name);
    for (int i = 0; i < 18; i++) chk($sformatf("%s[%0d]", name, i), ops[i], exp_ops[i]);
  endtask

  task automatic check_flags(input string name);
    chk({name, "_err_len"}, err_len, exp_el);
    chk({name, "_err_timeout"}, err_timeout, exp_et);
  endtask

  // Called and returns at a negedge.
  task automatic send_byte(input logic [DW-1:0] d, input bit last, input int gap_max);
    int g;
    g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (g) begin s_valid = 1'b0; @(negedge clk); end
    s_valid = 1'b1; s_data = d; s_last = last;
    for (int w = 0; ; w++) begin
      if (s_ready) begin @(posedge clk); @(negedge clk); break; end
      if (w >= 100) begin chk("ready_wait_timeout", 0, 1); break; end
      @(negedge clk);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit nom, input int gap);
    logic [DW-1:0] d;
    for (int i = 0; i < len; i++) begin
      if (nom) d = (i < 9) ? DW'(i + 1) : DW'(18 - i);
      else     d = DW'($urandom);
      send_byte(d, i == len - 1, gap);
      if (i < 18) exp_ops[i] = d;
      if (i == 17 && len > 18) chk("err_len_at_byte17", err_len, 1);
    end
    if (len != 18) exp_el = 1'b1;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    exp_el = 1'b0; exp_et = 1'b0;
  endtask

  task automatic check_mac();
    int c, k;
    int exp_c [9];
    exp_c = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        c = 0;
        for (k = 0; k < 3; k++) c += int'(ops[i*3+k]) * int'(ops[9+k*3+j]);
        chk($sformatf("mac_c%0d%0d", i + 1, j + 1), c, exp_c[i*3+j]);
      end
  endtask

  // Entered at the negedge right after the byte17 edge.
  task automatic run_mac(input int lat, input int hold);
    bit bad;
    bad = 1'b0;
    chk("start_after_b17", start, 1);
    chk("ready_low_in_run", s_ready, 0);
    chk("busy_in_run", busy, 1);
    repeat (lat) begin @(negedge clk); if (!start || s_ready || ops_differ()) bad = 1'b1; end
    done = 1'b1;
    repeat (hold) begin @(negedge clk); if (start || s_ready || !busy || ops_differ()) bad = 1'b1; end
    done = 1'b0;
    @(negedge clk);
    chk("run_release_behaviour", bad, 0);
    chk("ready_after_done_low", s_ready, 1);
    chk("busy_after_done_low", busy, 0);
    chk("start_after_done_low", start, 0);
    check_ops("ops_after_run");
  endtask

  initial begin
    int t0, n, len;
    vecs[0] = '{len: 18, gap: 0, nom: 1'b1, clr_before: 1'b0, exp_start: 1'b1, exp_err_len: 1'b0};
    vecs[1] = '{len: 6,  gap: 2, nom: 1'b0, clr_before: 1'b0, exp_start: 1'b0, exp_err_len: 1'b1};
    vecs[2] = '{len: 18, gap: 3, nom: 1'b1, clr_before: 1'b0, exp_start: 1'b1, exp_err_len: 1'b1};
    vecs[3] = '{len: 20, gap: 0, nom: 1'b0, clr_before: 1'b1, exp_start: 1'b0, exp_err_len: 1'b1};
    vecs[4] = '{len: 18, gap: 1, nom: 1'b0, clr_before: 1'b1, exp_start: 1'b1, exp_err_len: 1'b0};
    for (int i = 0; i < 18; i++) exp_ops[i] = '0;

    // Reset state
    #1;
    chk("rst_start", start, 0); chk("rst_ready", s_ready, 0); chk("rst_busy", busy, 0);
    check_flags("rst");
    check_ops("rst_ops");
    @(negedge clk); rst = 1'b1;
    chk("ready_before_first_edge", s_ready, 0);
    @(negedge clk);
    chk("ready_first_edge", s_ready, 1);

    // Scenario table
    foreach (vecs[v]) begin
      if (vecs[v].clr_before) begin pulse_clr(); chk($sformatf("v%0d_clr", v), err_len, 0); end
      t0 = cyc;
      send_frame(vecs[v].len, vecs[v].nom, vecs[v].gap);
      if (vecs[v].gap == 0) chk($sformatf("v%0d_frame_cycles", v), cyc - t0, vecs[v].len);
      chk($sformatf("v%0d_err_len", v), err_len, vecs[v].exp_err_len);
      chk($sformatf("v%0d_start", v), start, vecs[v].exp_start);
      check_ops($sformatf("v%0d_ops", v));
      if (vecs[v].exp_start) begin
        if (vecs[v].nom) check_mac();
        run_mac(v, 5);
      end
    end
    pulse_clr();
    chk("clr_after_long", err_len, 0);

    // Same-edge set and clear: set wins
    send_byte(8'h11, 1'b0, 0); exp_ops[0] = 8'h11;
    send_byte(8'h22, 1'b0, 0); exp_ops[1] = 8'h22;
    s_valid = 1'b1; s_data = 8'h33; s_last = 1'b1; clr_err = 1'b1;
    @(posedge clk); @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; clr_err = 1'b0;
    exp_ops[2] = 8'h33; exp_el = 1'b1;
    chk("set_beats_clear", err_len, 1);
    check_ops("short_ops");
    pulse_clr();

    // Stalled MAC
    send_frame(18, 1'b0, 1);
    n = 0;
    while (start && n < 2000) begin n++; @(negedge clk); end
    exp_et = 1'b1;
    chk("timeout_run_cycles", n, TO);
    check_flags("timeout");
    chk("timeout_start_low", start, 0);
    @(negedge clk);
    chk("timeout_ready", s_ready, 1);
    chk("timeout_busy", busy, 0);
    pulse_clr();

    // Reset mid-RUN
    send_frame(18, 1'b1, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 18; i++) exp_ops[i] = '0;
    chk("midrun_rst_start", start, 0);
    chk("midrun_rst_ready", s_ready, 0);
    chk("midrun_rst_busy", busy, 0);
    check_ops("midrun_rst_ops");
    @(negedge clk); rst = 1'b1;
    chk("midrun_ready_pre_edge", s_ready, 0);
    @(negedge clk);
    chk("midrun_ready_post_edge", s_ready, 1);

    // Randomized frames against the frame-level model
    for (int f = 0; f < 25; f++) begin
      n = int'($urandom_range(9, 0));
      if (n < 6)      len = 18;
      else if (n < 8) len = int'($urandom_range(17, 1));
      else            len = int'($urandom_range(24, 19));
      if ($urandom_range(3, 0) == 0) pulse_clr();
      send_frame(len, 1'b0, int'($urandom_range(3, 0)));
      chk($sformatf("rnd%0d_start", f), start, len == 18);
      check_flags($sformatf("rnd%0d", f));
      check_ops($sformatf("rnd%0d_ops", f));
      if (len == 18 && start) run_mac(int'($urandom_range(6, 0)), int'($urandom_range(4, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
